pixel_readout_buffer: RTL and testbench
=======================================

// Module: pixel_readout_buffer
//
// PURPOSE
// Downstream of camera_control: captures pixel-array ADC column data during
// the controller's readout phase (nre1/nre2 row enables, adc strobe), builds
// complete 2-row frames, and streams pixels out one per cycle over a
// valid/ready interface. Double-banked: frame N+1 is captured while frame N
// drains.
//
// PARAMETERS
// SIZE   2  columns per row; rows fixed at 2 (nre1 -> row 0, nre2 -> row 1)
// ADC_W  8  bits per pixel sample
//
// PORTS
// clk        in   1             system clock, all state on rising edge
// reset      in   1             asynchronous, active-high; clears all state
// nre1       in   1             active-low row-0 read enable from camera_control
// nre2       in   1             active-low row-1 read enable from camera_control
// adc        in   1             ADC convert strobe from camera_control
// erase      in   1             frame abort; discards the partial frame in the write bank
// adc_data   in   SIZE*ADC_W    column samples; column c = [c*ADC_W +: ADC_W]
// pix_ready  in   1             downstream ready
// clear_err  in   1             clears the sticky flags
// pix_valid  out  1             pix_data valid
// pix_data   out  ADC_W         pixel value
// pix_row    out  1             row of current pixel
// pix_col    out  $clog2(SIZE)  column of current pixel
// pix_last   out  1             high with the final pixel of a frame
// frame_done out  1             1-cycle pulse when a frame completes capture
// overflow   out  1             sticky: capture dropped because the write bank was full
// proto_err  out  1             sticky: adc edge seen with nre1 and nre2 both low
//
// BEHAVIOUR
// - Reset: all outputs 0; wr_bank = rd_bank = 0; both banks empty; row flags 0;
//   adc_q = 0. Reset asserted mid-stream abandons the frame with no pix_last.
// - Edge detect: adc_q <= adc. Capture event = adc & ~adc_q (one per strobe,
//   regardless of strobe length).
// - Row decode at the capture event:
//   - nre1=0, nre2=1: row 0.
//   - nre1=1, nre2=0: row 1.
//   - both 1: ignored.
//   - both 0: ignored, and proto_err <= 1.
// - Capture: if bank[wr_bank] is not full, all SIZE columns of adc_data are
//   written to row r of that bank on that edge, and row_valid[r] <= 1.
//   A repeated row overwrites the earlier data.
// - Write bank full at the capture event: data dropped, overflow <= 1, no
//   state change.
// - Frame complete: on the cycle after both row_valid bits are 1:
//   - full[wr_bank] <= 1
//   - row_valid <= 0
//   - wr_bank toggles
//   - frame_done pulses for 1 cycle
// - erase=1: row_valid <= 0 (partial frame lost); full banks are untouched.
//   erase wins over a simultaneous capture event.
// - Read FSM states:
//   - IDLE: if full[rd_bank], go to STREAM with idx = 0; pix_valid rises on
//     the next cycle (2 cycles min. from completion of capture to first
//     pix_valid).
//   - STREAM: pix_valid = 1. Order: row 0 col 0..SIZE-1, then row 1
//     col 0..SIZE-1. idx advances only when pix_valid & pix_ready. While
//     ready is low, pix_data/row/col/last hold stable.
//   - pix_last = 1 when idx = 2*SIZE-1. On that transfer: full[rd_bank] <= 0,
//     rd_bank toggles, state -> IDLE. Back-to-back frames may therefore
//     show a 1-cycle valid gap.
// - Simultaneous events: completion into one bank and release of the other
//   bank in the same cycle are both honoured.
// - clear_err=1 clears overflow and proto_err. A same-cycle set wins over
//   the clear.
// - When idle, pix_data/row/col/last hold their last value; only pix_valid
//   qualifies them.
//
// TESTING
// 1 Reset, then row0 adc edge with data {8'h22,8'h11}, then row1 edge with
//   {8'h44,8'h33}, ready=1 -> frame_done pulse; stream 11,22,33,44 with
//   row/col 0/0,0/1,1/0,1/1; pix_last on 44.
// 2 Same frame, ready toggling 1,0,0,1,... -> no pixel lost or duplicated;
//   data stable while ready=0.
// 3 Capture 3 frames with ready=0 -> first two fill both banks, third
//   frame's edges raise overflow; ready=1 drains frames 1 then 2 intact.
// 4 Row0 captured, erase pulse, then row1 + row0 -> no frame_done until
//   both rows re-captured after erase; streamed data is the post-erase data.
// 5 adc held high 5 cycles under nre1=0 -> exactly one capture. adc edge
//   with nre1=nre2=0 -> proto_err=1, nothing captured; clear_err -> 0.
// 6 Assert reset mid-stream after 2 pixels -> pix_valid=0 immediately,
//   both banks empty; a new frame then streams normally from col 0.

Source files
------------

// File: rtl/pixel_readout_buffer_if.sv
// Pixel stream interface between pixel_readout_buffer and its consumer.
//
// Purpose : carries one pixel per transfer with a valid/ready handshake,
//           plus the pixel's frame coordinates and an end-of-frame marker.
// Signals : pix_valid  producer -> consumer  pix_data/row/col/last are meaningful
//           pix_ready  consumer -> producer  consumer accepts the pixel this cycle
//           pix_data   ADC_W-bit pixel value
//           pix_row    row of the pixel (0 or 1)
//           pix_col    column of the pixel (0..SIZE-1)
//           pix_last   final pixel of the frame
// Modports: master = pixel producer (the buffer), slave = pixel consumer.
interface pixel_readout_buffer_if #(
  parameter int SIZE  = 2,
  parameter int ADC_W = 8
);
  localparam int COL_W = $clog2(SIZE);

  logic             pix_valid;
  logic             pix_ready;
  logic [ADC_W-1:0] pix_data;
  logic             pix_row;
  logic [COL_W-1:0] pix_col;
  logic             pix_last;

  modport master (
    output pix_valid,
    output pix_data,
    output pix_row,
    output pix_col,
    output pix_last,
    input  pix_ready
  );

  modport slave (
    input  pix_valid,
    input  pix_data,
    input  pix_row,
    input  pix_col,
    input  pix_last,
    output pix_ready
  );
endinterface

// File: rtl/pixel_readout_buffer.sv
// pixel_readout_buffer
//
// Purpose : captures ADC column samples during camera_control's readout phase,
//           assembles 2-row frames in one of two banks, and streams each
//           completed frame out one pixel per transfer. One bank fills while
//           the other drains.
// Ports   : clk        system clock, rising edge
//           reset      asynchronous, active-high; clears all control and outputs
//           nre1/nre2  active-low row enables (nre1 -> row 0, nre2 -> row 1)
//           adc        ADC convert strobe; its rising edge captures adc_data
//           erase      discards the partially captured frame
//           adc_data   SIZE column samples, column c at [c*ADC_W +: ADC_W]
//           clear_err  clears the sticky overflow / proto_err flags
//           pix        pixel stream (master side of pixel_readout_buffer_if)
//           frame_done one-cycle pulse when a frame finishes capture
//           overflow   sticky: a row capture was dropped, write bank full
//           proto_err  sticky: adc edge with both row enables asserted
// SIZE must be a power of two >= 2.
module pixel_readout_buffer #(
  parameter int SIZE  = 2,
  parameter int ADC_W = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  nre1,
  input  logic                  nre2,
  input  logic                  adc,
  input  logic                  erase,
  input  logic [SIZE*ADC_W-1:0] adc_data,
  input  logic                  clear_err,
  pixel_readout_buffer_if.master pix,
  output logic                  frame_done,
  output logic                  overflow,
  output logic                  proto_err
);

  localparam int COL_W = $clog2(SIZE);

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } rd_state_t;

  // Frame storage: [bank][row][column]. Never read before written because a
  // bank is only streamed once its full flag is set.
  logic [ADC_W-1:0] mem [2][2][SIZE];

  // Capture-side control
  logic       adc_q;
  logic [1:0] row_valid, row_valid_nxt;
  logic [1:0] full, full_nxt;
  logic       wr_bank;

  logic cap_evt, row_hit, both_low, cap_row;
  logic complete, tgt_bank, cap_try, cap_ok, cap_drop;

  // Read-side control
  rd_state_t        state, state_nxt;
  logic             rd_bank;
  logic             load_first, advance, release_bank;
  logic             nxt_row;
  logic [COL_W-1:0] nxt_col;
  logic [ADC_W-1:0] nxt_data;
  logic             nxt_last;

  // Registered pixel outputs; they hold while idle or stalled.
  logic [ADC_W-1:0] pix_data_r;
  logic             pix_row_r;
  logic [COL_W-1:0] pix_col_r;
  logic             pix_last_r;

  // ---- capture decode ----
  assign cap_evt  = adc & ~adc_q;
  assign row_hit  = nre1 ^ nre2;
  assign both_low = ~nre1 & ~nre2;
  // With exactly one enable low, nre1 high means row 1 is selected.
  assign cap_row  = nre1;

  // A frame whose rows are both valid is committed on the following cycle
  // unless erase aborts it in that same cycle.
  assign complete = (&row_valid) & ~erase;
  // A capture landing in the commit cycle belongs to the next frame, which
  // lives in the other bank.
  assign tgt_bank = complete ? ~wr_bank : wr_bank;
  assign cap_try  = cap_evt & row_hit & ~erase;
  assign cap_ok   = cap_try & ~full[tgt_bank];
  assign cap_drop = cap_try &  full[tgt_bank];

  always_comb begin
    row_valid_nxt = row_valid;
    if (erase || complete) row_valid_nxt = '0;
    if (cap_ok) row_valid_nxt[cap_row] = 1'b1;
  end

  // Commit and release always target different banks: a bank still being
  // filled is never full, and only a full bank can be released.
  always_comb begin
    full_nxt = full;
    if (complete)     full_nxt[wr_bank] = 1'b1;
    if (release_bank) full_nxt[rd_bank] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      adc_q      <= 1'b0;
      row_valid  <= '0;
      full       <= '0;
      wr_bank    <= 1'b0;
      frame_done <= 1'b0;
      overflow   <= 1'b0;
      proto_err  <= 1'b0;
    end else begin
      adc_q      <= adc;
      row_valid  <= row_valid_nxt;
      full       <= full_nxt;
      wr_bank    <= wr_bank ^ complete;
      frame_done <= complete;
      // A new error in the same cycle as clear_err stays set.
      overflow   <= cap_drop | (overflow & ~clear_err);
      proto_err  <= (cap_evt & both_low) | (proto_err & ~clear_err);
    end
  end

  always_ff @(posedge clk) begin
    if (cap_ok) begin
      for (int c = 0; c < SIZE; c++) begin
        mem[tgt_bank][cap_row][c] <= adc_data[c*ADC_W +: ADC_W];
      end
    end
  end

  // ---- read FSM ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      rd_bank <= 1'b0;
    end else begin
      state   <= state_nxt;
      rd_bank <= rd_bank ^ release_bank;
    end
  end

  always_comb begin
    state_nxt    = state;
    load_first   = 1'b0;
    advance      = 1'b0;
    release_bank = 1'b0;
    unique case (state)
      IDLE: begin
        if (full[rd_bank]) begin
          state_nxt  = STREAM;
          load_first = 1'b1;
        end
      end
      STREAM: begin
        if (pix.pix_ready) begin
          if (pix_last_r) begin
            release_bank = 1'b1;
            state_nxt    = IDLE;
          end else begin
            advance = 1'b1;
          end
        end
      end
    endcase
  end

  // Next pixel position: row 0 columns first, then row 1.
  always_comb begin
    nxt_row = pix_row_r;
    nxt_col = pix_col_r;
    if (load_first) begin
      nxt_row = 1'b0;
      nxt_col = '0;
    end else if (pix_col_r == COL_W'(SIZE - 1)) begin
      nxt_row = 1'b1;
      nxt_col = '0;
    end else begin
      nxt_col = pix_col_r + COL_W'(1);
    end
  end

  assign nxt_data = mem[rd_bank][nxt_row][nxt_col];
  assign nxt_last = nxt_row & (nxt_col == COL_W'(SIZE - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pix_data_r <= '0;
      pix_row_r  <= 1'b0;
      pix_col_r  <= '0;
      pix_last_r <= 1'b0;
    end else if (load_first || advance) begin
      pix_data_r <= nxt_data;
      pix_row_r  <= nxt_row;
      pix_col_r  <= nxt_col;
      pix_last_r <= nxt_last;
    end
  end

  assign pix.pix_valid = (state == STREAM);
  assign pix.pix_data  = pix_data_r;
  assign pix.pix_row   = pix_row_r;
  assign pix.pix_col   = pix_col_r;
  assign pix.pix_last  = pix_last_r;

endmodule

// File: tb/tb_pixel_readout_buffer.sv
// Directed bench for pixel_readout_buffer: captures frames through the
// camera-side strobes and checks the streamed pixels and status flags
// against hand-computed values.
module tb_pixel_readout_buffer;
  localparam int SIZE  = 2;
  localparam int ADC_W = 8;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  nre1, nre2, adc, erase, clear_err;
  logic [SIZE*ADC_W-1:0] adc_data;
  logic                  frame_done, overflow, proto_err;

  int vectors     = 0;
  int miscompares = 0;

  pixel_readout_buffer_if #(.SIZE(SIZE), .ADC_W(ADC_W)) pif ();

  pixel_readout_buffer #(.SIZE(SIZE), .ADC_W(ADC_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .nre1      (nre1),
    .nre2      (nre2),
    .adc       (adc),
    .erase     (erase),
    .adc_data  (adc_data),
    .clear_err (clear_err),
    .pix       (pif),
    .frame_done(frame_done),
    .overflow  (overflow),
    .proto_err (proto_err)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One strobe on the given row: rising adc edge, then strobe and enables drop.
  task automatic capture(input logic row, input logic [15:0] d);
    nre1     = row;
    nre2     = ~row;
    adc_data = d;
    adc      = 1'b1;
    tick();
    adc  = 1'b0;
    nre1 = 1'b1;
    nre2 = 1'b1;
    tick();
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (pif.pix_valid !== 1'b1 && n < 12) begin
      tick();
      n++;
    end
    chk($sformatf("%s_valid_wait", tag), {31'd0, pif.pix_valid}, 32'd1);
  endtask

  task automatic expect_pix(input string tag, input logic [7:0] d, input logic r,
                            input logic c, input logic l);
    chk($sformatf("%s_valid", tag), {31'd0, pif.pix_valid}, 32'd1);
    chk($sformatf("%s_data", tag),  {24'd0, pif.pix_data}, {24'd0, d});
    chk($sformatf("%s_row", tag),   {31'd0, pif.pix_row},  {31'd0, r});
    chk($sformatf("%s_col", tag),   {31'd0, pif.pix_col},  {31'd0, c});
    chk($sformatf("%s_last", tag),  {31'd0, pif.pix_last}, {31'd0, l});
  endtask

  // Drain one frame with ready held high; px[7:0] is the first pixel.
  task automatic drain(input string tag, input logic [31:0] px);
    pif.pix_ready = 1'b1;
    wait_valid(tag);
    for (int i = 0; i < 4; i++) begin
      expect_pix($sformatf("%s_p%0d", tag, i), px[i*8 +: 8], (i >= 2), i[0], (i == 3));
      tick();
    end
  endtask

  initial begin
    int pat [12];
    int exp_i;
    logic [31:0] f2;

    reset = 1'b1; nre1 = 1'b1; nre2 = 1'b1; adc = 1'b0; erase = 1'b0;
    clear_err = 1'b0; adc_data = '0; pif.pix_ready = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();

    // Reset state
    chk("rst_valid",      {31'd0, pif.pix_valid}, 32'd0);
    chk("rst_data",       {24'd0, pif.pix_data},  32'd0);
    chk("rst_last",       {31'd0, pif.pix_last},  32'd0);
    chk("rst_row",        {31'd0, pif.pix_row},   32'd0);
    chk("rst_col",        {31'd0, pif.pix_col},   32'd0);
    chk("rst_frame_done", {31'd0, frame_done},    32'd0);
    chk("rst_overflow",   {31'd0, overflow},      32'd0);
    chk("rst_proto_err",  {31'd0, proto_err},     32'd0);

    // 1: basic frame, ready high, 2-cycle capture-to-valid latency
    capture(1'b0, 16'h2211);
    capture(1'b1, 16'h4433);
    chk("t1_frame_done",  {31'd0, frame_done},    32'd1);
    chk("t1_valid_early", {31'd0, pif.pix_valid}, 32'd0);
    tick();
    chk("t1_frame_done_pulse", {31'd0, frame_done},    32'd0);
    chk("t1_valid_latency",    {31'd0, pif.pix_valid}, 32'd1);
    drain("t1", 32'h44332211);
    chk("t1_valid_end", {31'd0, pif.pix_valid}, 32'd0);
    chk("t1_data_hold", {24'd0, pif.pix_data},  32'h44);

    // 2: ready toggling; each pixel must appear exactly once and hold while stalled
    pif.pix_ready = 1'b0;
    capture(1'b0, 16'h2211);
    capture(1'b1, 16'h4433);
    chk("t2_frame_done", {31'd0, frame_done}, 32'd1);
    tick();
    pat = '{1, 0, 0, 1, 0, 1, 0, 0, 1, 1, 1, 1};
    f2 = 32'h44332211;
    exp_i = 0;
    for (int k = 0; k < 12; k++) begin
      if (exp_i == 4) break;
      pif.pix_ready = pat[k][0];
      expect_pix($sformatf("t2_k%0d", k), f2[exp_i*8 +: 8], (exp_i >= 2), exp_i[0], (exp_i == 3));
      tick();
      if (pat[k] == 1) exp_i++;
    end
    chk("t2_valid_end", {31'd0, pif.pix_valid}, 32'd0);

    // 3: both banks fill, third frame overflows, first two drain intact
    pif.pix_ready = 1'b0;
    capture(1'b0, 16'h0201);
    capture(1'b1, 16'h0403);
    capture(1'b0, 16'h0605);
    capture(1'b1, 16'h0807);
    chk("t3_no_overflow_yet", {31'd0, overflow}, 32'd0);
    capture(1'b0, 16'h0A09);
    chk("t3_overflow", {31'd0, overflow}, 32'd1);
    capture(1'b1, 16'h0C0B);
    chk("t3_no_frame_done", {31'd0, frame_done}, 32'd0);
    drain("t3a", 32'h04030201);
    drain("t3b", 32'h08070605);
    tick();
    tick();
    chk("t3_third_dropped", {31'd0, pif.pix_valid}, 32'd0);
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    chk("t3_overflow_clear", {31'd0, overflow}, 32'd0);

    // 4: erase discards a partial frame
    pif.pix_ready = 1'b1;
    capture(1'b0, 16'h1211);
    erase = 1'b1;
    tick();
    erase = 1'b0;
    capture(1'b1, 16'h1413);
    chk("t4_no_frame_done", {31'd0, frame_done}, 32'd0);
    tick();
    chk("t4_no_frame_done2", {31'd0, frame_done},    32'd0);
    chk("t4_no_valid",       {31'd0, pif.pix_valid}, 32'd0);
    capture(1'b0, 16'h2221);
    chk("t4_frame_done", {31'd0, frame_done}, 32'd1);
    drain("t4", 32'h14132221);

    // 5: long strobe captures once; both enables low flags proto_err
    nre1 = 1'b0; nre2 = 1'b1; adc_data = 16'h3231; adc = 1'b1;
    tick();
    adc_data = 16'hEEEE;
    repeat (4) tick();
    adc = 1'b0; nre1 = 1'b1;
    tick();
    nre1 = 1'b0; nre2 = 1'b0; adc_data = 16'h5555; adc = 1'b1;
    tick();
    adc = 1'b0; nre1 = 1'b1; nre2 = 1'b1;
    tick();
    chk("t5_proto_err",   {31'd0, proto_err},     32'd1);
    chk("t5_no_frame",    {31'd0, frame_done},    32'd0);
    chk("t5_no_valid",    {31'd0, pif.pix_valid}, 32'd0);
    chk("t5_no_overflow", {31'd0, overflow},      32'd0);
    capture(1'b1, 16'h3433);
    chk("t5_frame_done", {31'd0, frame_done}, 32'd1);
    drain("t5", 32'h34333231);
    chk("t5_proto_err_held", {31'd0, proto_err}, 32'd1);
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    chk("t5_proto_err_clear", {31'd0, proto_err}, 32'd0);

    // 6: reset in the middle of a stream
    pif.pix_ready = 1'b1;
    capture(1'b0, 16'h4241);
    capture(1'b1, 16'h4443);
    wait_valid("t6");
    expect_pix("t6_p0", 8'h41, 1'b0, 1'b0, 1'b0);
    tick();
    expect_pix("t6_p1", 8'h42, 1'b0, 1'b1, 1'b0);
    tick();
    expect_pix("t6_p2", 8'h43, 1'b1, 1'b0, 1'b0);
    reset = 1'b1;
    #1;
    chk("t6_rst_valid", {31'd0, pif.pix_valid}, 32'd0);
    chk("t6_rst_data",  {24'd0, pif.pix_data},  32'd0);
    chk("t6_rst_last",  {31'd0, pif.pix_last},  32'd0);
    tick();
    reset = 1'b0;
    tick();
    tick();
    chk("t6_banks_empty", {31'd0, pif.pix_valid}, 32'd0);
    capture(1'b0, 16'h5251);
    capture(1'b1, 16'h5453);
    chk("t6_frame_done", {31'd0, frame_done}, 32'd1);
    drain("t6n", 32'h54535251);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
